// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout ball/block logic.
package breakout_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    APPLY    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  // Direction bits latched from the granted column.
  typedef struct packed {
    logic u;
    logic d;
    logic l;
    logic r;
  } hit_bits_t;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  localparam int DEFAULT_NUM_COLS = 7;
  localparam int IDX_W            = 3;

endpackage

// File: rtl/breakout_rr_picker.sv
// Combinational round-robin search: first requester at or after last_grant+1, wrapping.
module breakout_rr_picker
  import breakout_pkg::*;
#(
  parameter int NUM_COLS = DEFAULT_NUM_COLS
) (
  input  logic [NUM_COLS-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  output logic                any,
  output logic [IDX_W-1:0]    idx
);

  // last_grant is always < NUM_COLS, so one conditional subtract wraps the offset.
  function automatic int cand(input logic [IDX_W-1:0] lg, input int k);
    int c;
    c = int'(lg) + k;
    if (c >= NUM_COLS) c = c - NUM_COLS;
    return c;
  endfunction

  always_comb begin
    any = |req;
    idx = '0;
    // Walk farthest-to-nearest so the nearest requester is the last write.
    for (int k = NUM_COLS; k >= 1; k--) begin
      if (req[cand(last_grant, k)]) idx = IDX_W'(cand(last_grant, k));
    end
  end

endmodule

// File: rtl/breakout_bounce_arbiter.sv
// Owns ball direction and block score; grants one block column per bounce, then cools down.
module breakout_bounce_arbiter
  import breakout_pkg::*;
#(
  parameter int NUM_COLS        = DEFAULT_NUM_COLS,
  parameter int COOLDOWN_FRAMES = 3,
  parameter int SCORE_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [NUM_COLS-1:0] hit_u,
  input  logic [NUM_COLS-1:0] hit_d,
  input  logic [NUM_COLS-1:0] hit_l,
  input  logic [NUM_COLS-1:0] hit_r,
  input  logic                wall_l,
  input  logic                wall_r,
  input  logic                wall_t,
  input  logic                paddle_hit,
  input  logic                serve,
  output logic                dir_x,
  output logic                dir_y,
  output logic                bounce_pulse,
  output logic [IDX_W-1:0]    grant_col,
  output logic                cooldown_active,
  output logic [SCORE_W-1:0]  score,
  output state_e              state_dbg
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int SUM_W = SCORE_W + 1;

  state_e             state_q, state_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               bounce_q, bounce_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  hit_bits_t          lat_q, lat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [NUM_COLS-1:0] col_req;
  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;
  logic [SUM_W-1:0]    score_sum;

  assign col_req = hit_u | hit_d | hit_l | hit_r;

  breakout_rr_picker #(.NUM_COLS(NUM_COLS)) u_picker (
    .req        (col_req),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dir_x_q      <= DIR_RIGHT;
      dir_y_q      <= DIR_UP;
      bounce_q     <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_COLS - 1);
      lat_q        <= '0;
      cnt_q        <= '0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      bounce_q     <= bounce_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      lat_q        <= lat_d;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    bounce_d     = 1'b0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    lat_d        = lat_q;
    cnt_d        = cnt_q;
    score_d      = score_q;
    score_sum    = {1'b0, score_q} + SUM_W'(grant_q) + SUM_W'(1);

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          lat_d.u = hit_u[pick_idx];
          lat_d.d = hit_d[pick_idx];
          lat_d.l = hit_l[pick_idx];
          lat_d.r = hit_r[pick_idx];
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (lat_q.r && !lat_q.l)      dir_x_d = DIR_RIGHT;
        else if (lat_q.l && !lat_q.r) dir_x_d = DIR_LEFT;
        else if (lat_q.l && lat_q.r)  dir_x_d = ~dir_x_q;
        if (lat_q.d && !lat_q.u)      dir_y_d = DIR_DOWN;
        else if (lat_q.u && !lat_q.d) dir_y_d = DIR_UP;
        else if (lat_q.u && lat_q.d)  dir_y_d = ~dir_y_q;
        score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        bounce_d     = 1'b1;
        last_grant_d = grant_q;
        cnt_d        = CNT_W'(COOLDOWN_FRAMES);
        state_d      = COOLDOWN;
      end
      COOLDOWN: begin
        if (cnt_q == '0)     state_d = IDLE;
        else if (frame_tick) cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Walls and paddle take priority over a block bounce on the same axis.
    if (wall_l && !wall_r)     dir_x_d = DIR_RIGHT;
    if (wall_r && !wall_l)     dir_x_d = DIR_LEFT;
    if (wall_t && !paddle_hit) dir_y_d = DIR_DOWN;
    if (paddle_hit && !wall_t) dir_y_d = DIR_UP;

    // Serve cancels whatever the FSM was doing this cycle, except the score history.
    if (serve) begin
      dir_x_d      = DIR_RIGHT;
      dir_y_d      = DIR_UP;
      cnt_d        = '0;
      state_d      = IDLE;
      score_d      = score_q;
      bounce_d     = 1'b0;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      lat_d        = lat_q;
    end
  end

  always_comb begin
    dir_x           = dir_x_q;
    dir_y           = dir_y_q;
    bounce_pulse    = bounce_q;
    grant_col       = grant_q;
    cooldown_active = (state_q == COOLDOWN);
    score           = score_q;
    state_dbg       = state_q;
  end

endmodule

// File: tb/tb_breakout_bounce_arbiter.sv
// Directed bench: dut_a uses a 3-frame cooldown, dut_b a zero cooldown; both share stimulus.
module tb_breakout_bounce_arbiter;
  import breakout_pkg::*;

  localparam int NC = 7;

  logic          clk = 1'b0;
  logic          reset, frame_tick;
  logic [NC-1:0] hit_u, hit_d, hit_l, hit_r;
  logic          wall_l, wall_r, wall_t, paddle_hit, serve;

  logic          a_dx, a_dy, a_bp, a_cd;
  logic [2:0]    a_gc;
  logic [15:0]   a_sc;
  state_e        a_st;
  logic          b_dx, b_dy, b_bp, b_cd;
  logic [2:0]    b_gc;
  logic [15:0]   b_sc;
  state_e        b_st;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  breakout_bounce_arbiter #(.NUM_COLS(NC), .COOLDOWN_FRAMES(3), .SCORE_W(16)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
    .wall_l(wall_l), .wall_r(wall_r), .wall_t(wall_t),
    .paddle_hit(paddle_hit), .serve(serve),
    .dir_x(a_dx), .dir_y(a_dy), .bounce_pulse(a_bp), .grant_col(a_gc),
    .cooldown_active(a_cd), .score(a_sc), .state_dbg(a_st)
  );

  breakout_bounce_arbiter #(.NUM_COLS(NC), .COOLDOWN_FRAMES(0), .SCORE_W(16)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
    .wall_l(wall_l), .wall_r(wall_r), .wall_t(wall_t),
    .paddle_hit(paddle_hit), .serve(serve),
    .dir_x(b_dx), .dir_y(b_dy), .bounce_pulse(b_bp), .grant_col(b_gc),
    .cooldown_active(b_cd), .score(b_sc), .state_dbg(b_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    frame_tick = 1'b0;
    hit_u = '0; hit_d = '0; hit_l = '0; hit_r = '0;
    wall_l = 1'b0; wall_r = 1'b0; wall_t = 1'b0;
    paddle_hit = 1'b0; serve = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0]  rr_col [4];
    logic [15:0] rr_sc  [4];
    rr_col = '{3'd0, 3'd5, 3'd0, 3'd5};
    rr_sc  = '{16'd1, 16'd7, 16'd8, 16'd14};

    // Reset values
    do_reset();
    chk("rst_dir_x", 32'(a_dx), 32'd1);
    chk("rst_dir_y", 32'(a_dy), 32'd0);
    chk("rst_score", 32'(a_sc), 32'd0);
    chk("rst_grant", 32'(a_gc), 32'd0);
    chk("rst_bounce", 32'(a_bp), 32'd0);
    chk("rst_cooldown", 32'(a_cd), 32'd0);
    chk("rst_state", 32'(a_st), 32'(IDLE));

    // Single column: one-cycle hit_r[2]
    hit_r = 7'b0000100;
    tick();
    hit_r = '0;
    chk("single_grant_latched", 32'(a_gc), 32'd2);
    chk("single_no_early_bounce", 32'(a_bp), 32'd0);
    chk("single_state_apply", 32'(a_st), 32'(APPLY));
    tick();
    chk("single_bounce", 32'(a_bp), 32'd1);
    chk("single_dir_x", 32'(a_dx), 32'd1);
    chk("single_score", 32'(a_sc), 32'd3);
    chk("single_cooldown_a", 32'(a_cd), 32'd1);
    tick();
    chk("single_bounce_one_cycle", 32'(a_bp), 32'd0);
    chk("single_b_back_idle", 32'(b_st), 32'(IDLE));

    // Round-robin on the zero-cooldown instance
    do_reset();
    hit_d = 7'b0100001;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk("rr_bounce", 32'(b_bp), 32'd1);
      chk("rr_grant", 32'(b_gc), 32'(rr_col[k]));
      chk("rr_score", 32'(b_sc), 32'(rr_sc[k]));
      tick();
    end
    chk("rr_dir_y_down", 32'(b_dy), 32'd1);
    hit_d = '0;

    // Cooldown: request held throughout, three frame ticks needed
    do_reset();
    hit_u = 7'b0000010;
    tick();
    tick();
    chk("cd_first_bounce", 32'(a_bp), 32'd1);
    chk("cd_first_score", 32'(a_sc), 32'd2);
    chk("cd_active", 32'(a_cd), 32'd1);
    for (int f = 0; f < 3; f++) begin
      tick();
      chk("cd_hold_active", 32'(a_cd), 32'd1);
      chk("cd_hold_no_bounce", 32'(a_bp), 32'd0);
      tick();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      chk("cd_tick_active", 32'(a_cd), 32'd1);
      chk("cd_tick_no_bounce", 32'(a_bp), 32'd0);
    end
    tick();
    chk("cd_released", 32'(a_cd), 32'd0);
    chk("cd_released_state", 32'(a_st), 32'(IDLE));
    tick();
    chk("cd_relatch_state", 32'(a_st), 32'(APPLY));
    tick();
    chk("cd_second_bounce", 32'(a_bp), 32'd1);
    chk("cd_second_score", 32'(a_sc), 32'd4);
    hit_u = '0;

    // Both horizontal bits on one column invert dir_x
    do_reset();
    hit_l = 7'b0010000;
    hit_r = 7'b0010000;
    tick();
    hit_l = '0;
    hit_r = '0;
    tick();
    chk("both_lr_dir_x", 32'(a_dx), 32'd0);
    chk("both_lr_score", 32'(a_sc), 32'd5);

    // Paddle wins over a block bounce on the same cycle
    do_reset();
    hit_d = 7'b0001000;
    tick();
    hit_d = '0;
    tick();
    chk("wall_pre_dir_y", 32'(b_dy), 32'd1);
    tick();
    hit_d = 7'b0001000;
    tick();
    hit_d = '0;
    paddle_hit = 1'b1;
    tick();
    paddle_hit = 1'b0;
    chk("paddle_wins_dir_y", 32'(b_dy), 32'd0);
    chk("paddle_apply_bounce", 32'(b_bp), 32'd1);
    chk("paddle_apply_score", 32'(b_sc), 32'd8);
    tick();
    wall_t = 1'b1;
    tick();
    wall_t = 1'b0;
    chk("wall_t_dir_y", 32'(b_dy), 32'd1);
    wall_r = 1'b1;
    tick();
    chk("wall_r_dir_x", 32'(a_dx), 32'd0);
    wall_l = 1'b1;
    tick();
    chk("wall_lr_unchanged", 32'(a_dx), 32'd0);
    wall_r = 1'b0;
    tick();
    wall_l = 1'b0;
    chk("wall_l_dir_x", 32'(a_dx), 32'd1);
    wall_t = 1'b1;
    paddle_hit = 1'b1;
    tick();
    wall_t = 1'b0;
    paddle_hit = 1'b0;
    chk("wall_t_paddle_unchanged", 32'(a_dy), 32'd1);

    // Serve during APPLY
    do_reset();
    hit_l = 7'b0000010;
    hit_d = 7'b0000010;
    tick();
    hit_l = '0;
    hit_d = '0;
    tick();
    chk("serve_pre_dir_x", 32'(b_dx), 32'd0);
    chk("serve_pre_dir_y", 32'(b_dy), 32'd1);
    chk("serve_pre_score", 32'(b_sc), 32'd2);
    tick();
    hit_l = 7'b0001000;
    tick();
    hit_l = '0;
    serve = 1'b1;
    tick();
    serve = 1'b0;
    chk("serve_dir_x", 32'(b_dx), 32'd1);
    chk("serve_dir_y", 32'(b_dy), 32'd0);
    chk("serve_no_bounce", 32'(b_bp), 32'd0);
    chk("serve_score_kept", 32'(b_sc), 32'd2);
    chk("serve_state_idle", 32'(b_st), 32'(IDLE));
    chk("serve_a_state_idle", 32'(a_st), 32'(IDLE));

    // Reset during COOLDOWN
    do_reset();
    hit_l = 7'b0100000;
    hit_d = 7'b0100000;
    tick();
    hit_l = '0;
    hit_d = '0;
    tick();
    chk("mid_pre_cooldown", 32'(a_cd), 32'd1);
    chk("mid_pre_score", 32'(a_sc), 32'd6);
    reset = 1'b1;
    serve = 1'b1;
    tick();
    reset = 1'b0;
    serve = 1'b0;
    chk("mid_rst_dir_x", 32'(a_dx), 32'd1);
    chk("mid_rst_dir_y", 32'(a_dy), 32'd0);
    chk("mid_rst_score", 32'(a_sc), 32'd0);
    chk("mid_rst_grant", 32'(a_gc), 32'd0);
    chk("mid_rst_bounce", 32'(a_bp), 32'd0);
    chk("mid_rst_cooldown", 32'(a_cd), 32'd0);
    chk("mid_rst_state", 32'(a_st), 32'(IDLE));

    // Score saturation: column 6 adds 7 per bounce; 9362*7 = 16'hFFFE
    do_reset();
    hit_r = 7'b1000000;
    for (int i = 1; i <= 9365; i++) begin
      tick();
      tick();
      if (i == 9362) chk("sat_below", 32'(b_sc), 32'h0000FFFE);
      if (i == 9363) chk("sat_reach", 32'(b_sc), 32'h0000FFFF);
      tick();
    end
    hit_r = '0;
    chk("sat_hold", 32'(b_sc), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/breakout_bounce_arbiter.md
# breakout_bounce_arbiter

- Single owner of the ball direction register and the block-hit score.
- Collects hit requests from all block-column modules, plus the wall, paddle and serve events.
- Grants one block column per bounce (round-robin), applies the column's latched U/D/L/R bits to the ball direction, then holds off further block hits for a frame-counted cooldown so one contact cannot fire multiple bounces.
- Sits between the block columns and the ball-motion logic.

## Interface
Parameters:
- NUM_COLS, 7, number of block columns arbitrated (C0..C6)
- COOLDOWN_FRAMES, 3, frame ticks during which block requests are ignored after a bounce (0 legal)
- SCORE_W, 16, score width

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- hit_u, hit_d, hit_l, hit_r  in  NUM_COLS each  per-column direction requests; bit i belongs to column i
- wall_l, wall_r, wall_t  in  1 each  ball touching the left, right or top wall
- paddle_hit  in  1  ball touching the paddle
- serve  in  1  launch a new ball
- dir_x  out  1  1 = right, 0 = left
- dir_y  out  1  1 = down, 0 = up
- bounce_pulse  out  1  one-cycle pulse when a block bounce is applied
- grant_col  out  3  index of the last granted column
- cooldown_active  out  1  high in state COOLDOWN
- score  out  SCORE_W  accumulated block score

## Operation
- Column request: col_req[i] = hit_u[i] | hit_d[i] | hit_l[i] | hit_r[i].
- FSM states:
  - IDLE. If any col_req is set, pick the first requesting column at or after last_grant+1, wrapping modulo NUM_COLS. Register grant_col and that column's four bits (lat_u/d/l/r). Next state is APPLY.
  - APPLY (exactly 1 cycle). Update the direction:
    - lat_r alone sets dir_x=1; lat_l alone sets dir_x=0; both set inverts dir_x.
    - lat_d alone sets dir_y=1; lat_u alone sets dir_y=0; both set inverts dir_y.
    - score += grant_col+1, saturating at all-ones.
    - bounce_pulse <= 1; last_grant <= grant_col; cooldown counter <= COOLDOWN_FRAMES; next state is COOLDOWN.
  - COOLDOWN. col_req is ignored. If the counter is 0, go to IDLE on the next edge; otherwise decrement on each frame_tick.
- Wall and paddle events apply in every state, per axis:
  - wall_l sets dir_x=1; wall_r sets dir_x=0; both together leave dir_x unchanged.
  - wall_t sets dir_y=1; paddle_hit sets dir_y=0; both together leave dir_y unchanged.
  - On any axis written in the same cycle by APPLY, the wall/paddle result wins.
- serve:
  - Forces dir_x=1, dir_y=0, counter=0, state IDLE.
  - Overrides APPLY, walls and paddle.
  - Does not clear score.
  - If serve coincides with APPLY, the score update and bounce_pulse are dropped.
- Reset values:
  - Ball and arbitration: dir_x=1, dir_y=0, state IDLE, last_grant=NUM_COLS-1 (first search starts at column 0).
  - Outputs: score=0, grant_col=0, bounce_pulse=0, cooldown_active=0, counter=0.
  - Reset beats serve.

## Timing
- A request sampled at edge N (state IDLE) latches the grant at that edge. The APPLY edge is N+1. dir, score and bounce_pulse are visible in the cycle after edge N+1.
- Net latency from request to direction change: 2 clocks.
- Requests are level-sensitive. They need not be held past edge N; later changes are ignored until IDLE returns.
- Cooldown length is between COOLDOWN_FRAMES and COOLDOWN_FRAMES+1 frames, depending on tick phase. With COOLDOWN_FRAMES=0, COOLDOWN lasts 1 cycle.
- Reset mid-operation discards latched bits and any pending APPLY on the next edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package breakout_pkg holds:
  - State enum: IDLE, APPLY, COOLDOWN.
  - DIR_RIGHT=1, DIR_LEFT=0, DIR_DOWN=1, DIR_UP=0.
  - Default NUM_COLS=7.
- One sub-module, breakout_rr_picker. It is purely combinational: inputs are req[NUM_COLS] and last_grant; outputs are any and idx.
- The arbiter owns all state.

## Test plan
- Single column: reset, pulse hit_r[2] for 1 cycle → grant_col=2, dir_x=1, score=3, bounce_pulse high exactly 1 cycle, 2 clocks after the request.
- Round-robin: hold hit_d[0] and hit_d[5] continuously with COOLDOWN_FRAMES=0 → grants alternate 0,5,0,5; score grows by 1,6,1,6.
- Cooldown: COOLDOWN_FRAMES=3, hit_u[1] then repeat hit_u[1] every cycle → no second bounce until 3 frame_ticks have passed; cooldown_active matches.
- Both bits set: dir_x=1 with hit_l[4] and hit_r[4] together → dir_x becomes 0.
- Wall overrides APPLY: dir_y=1, hit_d[3] in the APPLY cycle with paddle_hit → dir_y=0; a lone wall_t later → dir_y=1.
- Score saturation: preload near 16'hFFFF via repeated column-6 hits → score holds at 16'hFFFF.
- Serve: serve in the APPLY cycle → dir=(1,0), state IDLE, no bounce_pulse, score unchanged.
- Reset: reset during COOLDOWN → all reset values on the next cycle.
